// File: rtl/wport_decoder_pipe.sv
// Registered multi-port write-enable decoder; same-address collisions replay lowest-port-first.
// Optional WPORT_DEC_CONFLICT_CNT_EN adds a saturating 16-bit deferred-issue counter (conflict_cnt).

module wport_dec_lane #(
    parameter int ADDR_W = 5,
    localparam int DEC_W = 1 << ADDR_W
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DEC_W-1:0]  dec
);
    assign dec = en ? (DEC_W'(1) << addr) : '0;
endmodule

module wport_decoder_pipe #(
    parameter int ADDR_W    = 5,
    parameter int NUM_PORTS = 2,
    localparam int DEC_W    = 1 << ADDR_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          wr_en,
    input  logic [NUM_PORTS*ADDR_W-1:0]   wr_addr,
    output logic                          in_ready,
    output logic [NUM_PORTS*DEC_W-1:0]    port_dec_q,
    output logic [DEC_W-1:0]              dec_q,
    output logic                          dec_valid_q,
    output logic                          conflict_q
`ifdef WPORT_DEC_CONFLICT_CNT_EN
    ,
    output logic [15:0]                   conflict_cnt
`endif
);
    logic [NUM_PORTS-1:0]        r_pend;
    logic [NUM_PORTS*ADDR_W-1:0] r_rep_addr;
    logic [NUM_PORTS-1:0]        w_act, w_lose, w_issue;
    logic [NUM_PORTS*ADDR_W-1:0] w_act_addr;
    logic [NUM_PORTS*DEC_W-1:0]  w_port_dec;
    logic [DEC_W-1:0]            w_dec;

    assign in_ready   = ~|r_pend;
    assign w_act      = in_ready ? wr_en   : r_pend;
    assign w_act_addr = in_ready ? wr_addr : r_rep_addr;

    // A port loses if any lower-indexed active port targets the same address.
    always_comb begin
        w_lose = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (q < p && w_act[p] && w_act[q] &&
                    w_act_addr[p*ADDR_W +: ADDR_W] == w_act_addr[q*ADDR_W +: ADDR_W])
                    w_lose[p] = 1'b1;
            end
        end
    end

    assign w_issue = w_act & ~w_lose;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
        wport_dec_lane #(.ADDR_W(ADDR_W)) u_lane (
            .en   (w_issue[g]),
            .addr (w_act_addr[g*ADDR_W +: ADDR_W]),
            .dec  (w_port_dec[g*DEC_W +: DEC_W])
        );
    end

    always_comb begin
        w_dec = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            w_dec = w_dec | w_port_dec[p*DEC_W +: DEC_W];
    end

    // Addresses are captured every cycle; only entries flagged in r_pend are ever used.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend      <= '0;
            r_rep_addr  <= '0;
            port_dec_q  <= '0;
            dec_q       <= '0;
            dec_valid_q <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            r_pend      <= w_lose;
            r_rep_addr  <= w_act_addr;
            port_dec_q  <= w_port_dec;
            dec_q       <= w_dec;
            dec_valid_q <= |w_dec;
            conflict_q  <= |w_lose;
        end
    end

`ifdef WPORT_DEC_CONFLICT_CNT_EN
    logic [15:0] r_cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (|w_lose && r_cnt != 16'hFFFF)
            r_cnt <= r_cnt + 16'd1;
    end
    assign conflict_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_wport_decoder_pipe.sv
// Scoreboard bench for wport_decoder_pipe (3 ports, 5-bit addresses): driver queues
// hand-computed expectations, a monitor pops and compares every output cycle.

module tb_wport_decoder_pipe;
    localparam int AW = 5;
    localparam int NP = 3;
    localparam int DW = 1 << AW;

    typedef struct {
        logic [NP*DW-1:0] pd;
        logic             c;
        logic             r;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP-1:0]     wr_en;
    logic [NP*AW-1:0]  wr_addr;
    logic              in_ready;
    logic [NP*DW-1:0]  port_dec_q;
    logic [DW-1:0]     dec_q;
    logic              dec_valid_q;
    logic              conflict_q;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    wport_decoder_pipe #(.ADDR_W(AW), .NUM_PORTS(NP)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .in_ready    (in_ready),
        .port_dec_q  (port_dec_q),
        .dec_q       (dec_q),
        .dec_valid_q (dec_valid_q),
        .conflict_q  (conflict_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NP*DW-1:0] act, input logic [NP*DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [NP-1:0] en, input logic [AW-1:0] a0, a1, a2,
                        input logic [DW-1:0] e0, e1, e2, input logic c, input logic r);
        exp_t e;
        @(negedge clk);
        wr_en   = en;
        wr_addr = {a2, a1, a0};
        e.pd = {e2, e1, e0};
        e.c  = c;
        e.r  = r;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    // Monitor: compares one queued expectation per output cycle.
    initial begin
        exp_t        e;
        logic [DW-1:0] d;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                d = '0;
                for (int p = 0; p < NP; p++) d = d | e.pd[p*DW +: DW];
                chk("port_dec_q",  port_dec_q, e.pd);
                chk("dec_q",       {{(NP-1)*DW{1'b0}}, dec_q}, {{(NP-1)*DW{1'b0}}, d});
                chk("dec_valid_q", {{NP*DW-1{1'b0}}, dec_valid_q}, {{NP*DW-1{1'b0}}, |d});
                chk("conflict_q",  {{NP*DW-1{1'b0}}, conflict_q},  {{NP*DW-1{1'b0}}, e.c});
                chk("in_ready",    {{NP*DW-1{1'b0}}, in_ready},    {{NP*DW-1{1'b0}}, e.r});
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        wr_en   = '0;
        wr_addr = '0;
        #3;
        chk("reset port_dec_q", port_dec_q, '0);
        chk("reset dec_q", {{(NP-1)*DW{1'b0}}, dec_q}, '0);
        chk("reset flags", {{NP*DW-2{1'b0}}, dec_valid_q, conflict_q}, '0);
        chk("reset in_ready", {{NP*DW-1{1'b0}}, in_ready}, {{NP*DW-1{1'b0}}, 1'b1});
        @(negedge clk);
        reset_n = 1'b1;

        // Single port, two ports on distinct addresses
        step(3'b001, 5'd5, 5'd0, 5'd0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1);
        step(3'b011, 5'd3, 5'd31, 5'd0, 32'h8, 32'h8000_0000, 32'h0, 1'b0, 1'b1);
        // Two-way collision on 7; changed inputs during the stall are ignored
        step(3'b011, 5'd7, 5'd7, 5'd0, 32'h80, 32'h0, 32'h0, 1'b1, 1'b0);
        step(3'b011, 5'd1, 5'd2, 5'd0, 32'h0, 32'h80, 32'h0, 1'b0, 1'b1);
        step(3'b011, 5'd1, 5'd2, 5'd0, 32'h2, 32'h4, 32'h0, 1'b0, 1'b1);
        idle();
        // Three-way collision on 2
        step(3'b111, 5'd2, 5'd2, 5'd2, 32'h4, 32'h0, 32'h0, 1'b1, 1'b0);
        step(3'b111, 5'd9, 5'd9, 5'd9, 32'h0, 32'h4, 32'h0, 1'b1, 1'b0);
        step(3'b111, 5'd9, 5'd9, 5'd9, 32'h0, 32'h0, 32'h4, 1'b0, 1'b1);
        idle();
        // Ports 0 and 2 collide while port 1 issues alongside
        step(3'b111, 5'd4, 5'd9, 5'd4, 32'h10, 32'h200, 32'h0, 1'b1, 1'b0);
        step(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h10, 1'b0, 1'b1);
        // Ports 1 and 2 collide on address 0
        step(3'b110, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1, 32'h0, 1'b1, 1'b0);
        step(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1, 1'b0, 1'b1);
        // Boundary addresses on all ports
        step(3'b111, 5'd0, 5'd31, 5'd16, 32'h1, 32'h8000_0000, 32'h1_0000, 1'b0, 1'b1);
        idle();

        // Reset during the second replay cycle drops port 2
        step(3'b111, 5'd2, 5'd2, 5'd2, 32'h4, 32'h0, 32'h0, 1'b1, 1'b0);
        step(3'b111, 5'd2, 5'd2, 5'd2, 32'h0, 32'h4, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        wr_en   = '0;
        #1;
        chk("midreset port_dec_q", port_dec_q, '0);
        chk("midreset dec_q", {{(NP-1)*DW{1'b0}}, dec_q}, '0);
        chk("midreset flags", {{NP*DW-2{1'b0}}, dec_valid_q, conflict_q}, '0);
        chk("midreset in_ready", {{NP*DW-1{1'b0}}, in_ready}, {{NP*DW-1{1'b0}}, 1'b1});
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        idle();
        step(3'b100, 5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h1000, 1'b0, 1'b1);
        idle();

        repeat (4) @(posedge clk);
        #3;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wport_decoder_pipe.md
Name: wport_decoder_pipe

Overview:
- Parametrised, registered multi-port write-enable decoder for register-file and physical-register write ports in the out-of-order core.
- Each port carries a binary address plus an enable. The block decodes each active port into a one-hot vector of width 2^ADDR_W and presents the per-port vectors and their OR one cycle later.
- Same-address collisions between ports in one cycle are serialised through an internal replay register. Upstream is back-pressured with in_ready while replays drain.

Parameters:
- ADDR_W, 5, address width; decoded width DEC_W = 2^ADDR_W.
- NUM_PORTS, 2, number of write ports (1..8).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- wr_en  input  NUM_PORTS  per-port write request.
- wr_addr  input  NUM_PORTS*ADDR_W  per-port address; port p occupies bits [p*ADDR_W +: ADDR_W].
- in_ready  output  1  high when new wr_en/wr_addr are accepted this cycle.
- port_dec_q  output  NUM_PORTS*DEC_W  registered per-port one-hot; port p at [p*DEC_W +: DEC_W].
- dec_q  output  DEC_W  registered OR of all port_dec_q vectors.
- dec_valid_q  output  1  registered; high when any bit of dec_q is set.
- conflict_q  output  1  registered; high when the issuing cycle deferred at least one port.

Behaviour:
- Reset (reset_n low, asynchronous) clears port_dec_q, dec_q, dec_valid_q, conflict_q, the replay register (pending mask plus stored addresses) and the conflict counter.
  - in_ready = 1 while in reset and on the first cycle after it.
- in_ready is combinational: in_ready = (replay pending mask == 0).
  - Inputs are sampled only when in_ready = 1.
  - When in_ready = 0, wr_en and wr_addr are ignored; upstream must hold them.
- Active set per cycle:
  - If replay is non-empty, the active set is the replay entries.
  - Otherwise, the active set is the ports with wr_en = 1.
- Arbitration per address: among active ports sharing an address, the lowest port index wins.
  - All losers are written into the replay register with their addresses.
  - Winners and non-colliding ports issue.
- Issue: on the next rising edge, port_dec_q[p] = one-hot(addr_p) for each issuing p, else 0.
  - dec_q = OR over ports; dec_valid_q = |dec_q.
  - Latency is exactly 1 cycle from acceptance to output for non-colliding requests.
- conflict_q = 1 in the output cycle whose issue deferred one or more ports, else 0.
- Replay drains one collision level per cycle.
  - With k ports on the same address, they issue on k consecutive cycles in ascending port order.
  - in_ready stays low until the final one issues.
- Different ports on different addresses never conflict and issue together.
- No-request cycle (in_ready = 1, wr_en = 0): all registered outputs are 0 next cycle.
- Address range: every address 0..DEC_W-1 is valid, so there is no out-of-range case. Bit index = address, LSB = address 0.
- Reset mid-replay drops pending entries; they are never issued.

Optional Feature:
- Macro: WPORT_DEC_CONFLICT_CNT_EN.
- With it defined:
  - Adds output conflict_cnt (16 bits, reset 0).
  - Increments by 1 on each cycle in which conflict_q is set in the next cycle, i.e. each deferring issue.
  - Saturates at 0xFFFF.
- Without it: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- NUM_PORTS=2: wr_en=01, addr0=5 → next cycle port_dec_q[0]=0x00000020, dec_q=0x00000020, dec_valid_q=1, conflict_q=0, in_ready stays 1.
- wr_en=11, addr0=3, addr1=31 → next cycle dec_q=0x80000008, port_dec_q[1]=0x80000000, conflict_q=0.
- wr_en=11, both addr 7:
  - in_ready drops to 0 the cycle after acceptance.
  - Cycle 1: port_dec_q[0]=0x80, port_dec_q[1]=0, conflict_q=1.
  - Cycle 2: port_dec_q[1]=0x80, port_dec_q[0]=0, conflict_q=0; in_ready returns to 1.
  - Changed inputs held during the stall must not be observed.
- NUM_PORTS=3, all addr 2 → dec_q=0x4 for three consecutive cycles from ports 0, 1, 2; conflict_q=1,1,0; in_ready low for two cycles.
- Assert reset_n low during the cycle-2 replay of the scenario above → all outputs 0 immediately; after release in_ready=1 and the pending port never issues.
- With WPORT_DEC_CONFLICT_CNT_EN: force 0x10000 colliding requests → conflict_cnt reaches 0xFFFF and holds; reset returns it to 0.
